// File: rtl/lego_speed_ramp.sv
// Button debounce + held-button speed ramp for one Power Functions motor channel.
// Output (pwm/speed/changed) is registered 1 cycle after a press event or step tick; no backpressure.
module lego_speed_ramp #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP_CYCLES     = 2500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              btn_brake,
    output logic [3:0]        pwm,
    output logic signed [3:0] speed,
    output logic              changed
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_CYCLES - 1);
    localparam int INC = 0;
    localparam int DEC = 1;
    localparam int BRK = 2;
    localparam logic signed [3:0] SPD_MAX = 4'sd7;
    localparam logic signed [3:0] SPD_MIN = -4'sd7;

    typedef enum logic [1:0] {
        ST_FLOAT,
        ST_RUN,
        ST_BRAKE
    } state_t;

    logic [2:0]      w_btn_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_deb;
    logic [2:0]      r_deb_q;
    logic [DB_W-1:0] r_db_cnt [3];
    logic [ST_W-1:0] r_step_cnt;

    logic [2:0]      w_press;
    logic            w_any_press;
    logic            w_one_held;
    logic            w_tick;
    logic            w_inc_step;
    logic            w_dec_step;

    state_t            r_state;
    state_t            w_state_nxt;
    logic signed [3:0] r_speed;
    logic signed [3:0] w_speed_nxt;
    logic [3:0]        r_pwm;
    logic [3:0]        w_pwm_nxt;
    logic              r_changed;

    assign w_btn_raw = {btn_brake, btn_dec, btn_inc};

    // Debounced value only follows the synchroniser after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_press     = r_deb & ~r_deb_q;
    assign w_any_press = |w_press;
    assign w_one_held  = r_deb[INC] ^ r_deb[DEC];
    assign w_tick      = w_one_held && !w_any_press && (r_step_cnt == ST_LAST);
    assign w_inc_step  = r_deb[INC] && !r_deb[DEC] && (w_press[INC] || w_tick);
    assign w_dec_step  = r_deb[DEC] && !r_deb[INC] && (w_press[DEC] || w_tick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt <= '0;
        end else if (w_any_press || !w_one_held || (r_step_cnt == ST_LAST)) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + ST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FLOAT;
            r_speed   <= '0;
            r_pwm     <= 4'b0000;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_speed   <= w_speed_nxt;
            r_pwm     <= w_pwm_nxt;
            r_changed <= (w_pwm_nxt != r_pwm);
        end
    end

    // Steps are ignored while braked and the brake is still held down.
    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_pwm_nxt   = 4'b0000;
        if (w_press[BRK]) begin
            w_state_nxt = ST_BRAKE;
            w_speed_nxt = 4'sd0;
        end else if (!((r_state == ST_BRAKE) && r_deb[BRK])) begin
            if (w_inc_step) begin
                if (r_speed != SPD_MAX) begin
                    w_speed_nxt = r_speed + 4'sd1;
                end
                w_state_nxt = (w_speed_nxt == 4'sd0) ? ST_FLOAT : ST_RUN;
            end else if (w_dec_step) begin
                if (r_speed != SPD_MIN) begin
                    w_speed_nxt = r_speed - 4'sd1;
                end
                w_state_nxt = (w_speed_nxt == 4'sd0) ? ST_FLOAT : ST_RUN;
            end
        end
        case (w_state_nxt)
            ST_RUN:   w_pwm_nxt = $unsigned(w_speed_nxt);
            ST_BRAKE: w_pwm_nxt = 4'b1000;
            default:  w_pwm_nxt = 4'b0000;
        endcase
    end

    assign pwm     = r_pwm;
    assign speed   = r_speed;
    assign changed = r_changed;

endmodule

// File: tb/tb_lego_speed_ramp.sv
// Directed stimulus pushes expected {pwm, speed, cycle} per changed pulse; a negedge monitor pops and compares.
module tb_lego_speed_ramp;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              btn_inc = 1'b0;
    logic              btn_dec = 1'b0;
    logic              btn_brake = 1'b0;
    logic [3:0]        pwm;
    logic signed [3:0] speed;
    logic              changed;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]        pwm;
        logic signed [3:0] spd;
        int                at;
    } exp_t;

    exp_t q[$];

    localparam logic [3:0] UP_PWM [7] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
    localparam int         UP_SPD [7] = '{1, 2, 3, 4, 5, 6, 7};
    localparam logic [3:0] DN_PWM [14] = '{4'b0110, 4'b0101, 4'b0100, 4'b0011, 4'b0010, 4'b0001, 4'b0000,
                                           4'b1111, 4'b1110, 4'b1101, 4'b1100, 4'b1011, 4'b1010, 4'b1001};
    localparam int         DN_SPD [14] = '{6, 5, 4, 3, 2, 1, 0, -1, -2, -3, -4, -5, -6, -7};
    localparam logic [3:0] RE_PWM [12] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111,
                                           4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
    localparam int         RE_SPD [12] = '{-6, -5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5};

    lego_speed_ramp #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_inc  (btn_inc),
        .btn_dec  (btn_dec),
        .btn_brake(btn_brake),
        .pwm      (pwm),
        .speed    (speed),
        .changed  (changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] p, input int s, input int at);
        exp_t e;
        e.pwm = p;
        e.spd = s[3:0];
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && changed) begin
            if (q.size() == 0) begin
                check("spurious_changed", changed, 0);
            end else begin
                e = q.pop_front();
                check("pwm", pwm, e.pwm);
                check("speed", speed, e.spd);
                check("changed_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual cycle=%0d required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int r;

        // Power-on reset values
        repeat (2) @(negedge clk);
        check("reset_pwm", pwm, 0);
        check("reset_speed", speed, 0);
        check("reset_changed", changed, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Bouncing inc, then clean hold: one press, ramp to +7 and saturate
        for (int i = 0; i < 10; i++) begin
            btn_inc = ~btn_inc;
            repeat (2) @(negedge clk);
        end
        btn_inc = 1'b1;
        k = cyc;
        for (int i = 0; i < 7; i++) push_exp(UP_PWM[i], UP_SPD[i], k + 7 + 8 * i);
        wait_until(k + 90);
        btn_inc = 1'b0;

        // Dec held from +7 through FLOAT down to -7
        wait_until(cyc + 10);
        btn_dec = 1'b1;
        k = cyc;
        for (int i = 0; i < 14; i++) push_exp(DN_PWM[i], DN_SPD[i], k + 7 + 8 * i);
        wait_until(k + 130);
        btn_dec = 1'b0;

        // Ramp up to +5, brake with inc still held, repeat brake, then restart
        wait_until(cyc + 10);
        btn_inc = 1'b1;
        k = cyc;
        for (int i = 0; i < 12; i++) push_exp(RE_PWM[i], RE_SPD[i], k + 7 + 8 * i);
        wait_until(k + 95);
        btn_brake = 1'b1;
        push_exp(4'b1000, 0, k + 102);
        wait_until(k + 140);
        btn_inc = 1'b0;
        wait_until(k + 150);
        btn_brake = 1'b0;
        wait_until(k + 160);
        btn_brake = 1'b1;
        wait_until(k + 170);
        btn_brake = 1'b0;
        wait_until(k + 185);
        btn_inc = 1'b1;
        k = cyc;
        push_exp(4'b0001, 1, k + 7);
        wait_until(k + 7);
        btn_inc = 1'b0;

        // Simultaneous inc+dec press and hold, then release dec
        wait_until(cyc + 10);
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        k = cyc;
        wait_until(k + 40);
        btn_dec = 1'b0;
        r = cyc;
        push_exp(4'b0010, 2, r + 14);
        push_exp(4'b0011, 3, r + 22);

        // Asynchronous reset mid-ramp with inc held
        wait_until(r + 25);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_pwm", pwm, 0);
        check("midrst_speed", speed, 0);
        check("midrst_changed", changed, 0);
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_until(cyc + 30);
        btn_inc = 1'b1;
        k = cyc;
        push_exp(4'b0001, 1, k + 7);
        wait_until(k + 7);
        btn_inc = 1'b0;
        wait_until(cyc + 20);

        check("pending_expectations", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
